dat_serial_wrapper: RTL and testbench

- Serialiser/deserialiser for the SD DAT0 line, one data bit per sd_clock in 1-bit bus mode.
- Sits between the DAT physical controller and the DAT pad.
- Write: frames one parallel word as start bit, data, CRC16 and end bit.
- Read: captures one framed word from the card and checks its CRC16.
- After a write, it receives the card's CRC status token and waits out the busy period.

---
 rtl/dat_serial_wrapper.sv | 185 ++++++++++++++++++
 tb/tb_dat_serial_wrapper.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dat_serial_wrapper.sv
// SD DAT0 serialiser/deserialiser for 1-bit bus mode: frames a word out with CRC16,
// captures a framed word in with CRC check, and collects the CRC status token plus busy.
module dat_serial_wrapper #(
  parameter int DATA_WIDTH = 32,
  parameter int CRC_WIDTH  = 16
) (
  input  logic                  sd_clock,
  input  logic                  reset,
  input  logic                  reset_wrapper,
  input  logic                  load_send,
  input  logic                  enable_pts_wrapper,
  input  logic                  enable_stp_wrapper,
  input  logic                  waiting_response,
  input  logic [DATA_WIDTH-1:0] dataPARALLEL,
  input  logic                  dat_in,
  output logic                  dat_out,
  output logic                  transmission_complete,
  output logic                  reception_complete,
  output logic [DATA_WIDTH-1:0] dataRead,
  output logic                  crc_error,
  output logic [2:0]            crc_status
);

  localparam int CNT_W = $clog2(DATA_WIDTH > CRC_WIDTH ? DATA_WIDTH : CRC_WIDTH);
  localparam logic [CRC_WIDTH-1:0] CRC_POLY = CRC_WIDTH'(16'h1021);

  typedef enum logic [3:0] {
    IDLE, TX_START, TX_DATA, TX_CRC, TX_END, TX_DONE,
    RX_WAIT, RX_DATA, RX_CRC, RX_END, RX_DONE,
    ST_WAIT, ST_BITS, ST_END, ST_BUSY, ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CRC_WIDTH-1:0]  crc_q, crc_d;
  logic [CRC_WIDTH-1:0]  rx_crc_q, rx_crc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_read_q, data_read_d;
  logic                  crc_error_q, crc_error_d;
  logic [2:0]            crc_status_q, crc_status_d;
  logic                  tx_active, rx_active;

  function automatic logic [CRC_WIDTH-1:0] crc_next(input logic [CRC_WIDTH-1:0] crc,
                                                    input logic b);
    logic fb;
    fb = crc[CRC_WIDTH-1] ^ b;
    crc_next = {crc[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

  assign tx_active = state_q inside {TX_START, TX_DATA, TX_CRC, TX_END, TX_DONE};
  assign rx_active = state_q inside {RX_WAIT, RX_DATA, RX_CRC, RX_END, RX_DONE,
                                     ST_WAIT, ST_BITS, ST_END, ST_BUSY, ST_DONE};

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    crc_d        = crc_q;
    rx_crc_d     = rx_crc_q;
    cnt_d        = cnt_q;
    data_read_d  = data_read_q;
    crc_error_d  = crc_error_q;
    crc_status_d = crc_status_q;
    // Losing the owning enable abandons the frame without touching results.
    if ((tx_active && !enable_pts_wrapper) || (rx_active && !enable_stp_wrapper)) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (enable_pts_wrapper && load_send) begin
            state_d = TX_START;
            shift_d = dataPARALLEL;
            crc_d   = '0;
          end else if (enable_stp_wrapper) begin
            state_d     = waiting_response ? ST_WAIT : RX_WAIT;
            crc_d       = '0;
            crc_error_d = 1'b0;
          end
        end
        TX_START: state_d = TX_DATA;
        TX_DATA: begin
          crc_d   = crc_next(crc_q, shift_q[DATA_WIDTH-1]);
          shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
          if (cnt_q == CNT_W'(DATA_WIDTH-1)) begin
            cnt_d   = '0;
            state_d = TX_CRC;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        TX_CRC: begin
          crc_d = {crc_q[CRC_WIDTH-2:0], 1'b0};
          if (cnt_q == CNT_W'(CRC_WIDTH-1)) begin
            cnt_d   = '0;
            state_d = TX_END;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        TX_END: state_d = TX_DONE;
        RX_WAIT: if (!dat_in) state_d = RX_DATA;
        RX_DATA: begin
          crc_d   = crc_next(crc_q, dat_in);
          shift_d = {shift_q[DATA_WIDTH-2:0], dat_in};
          if (cnt_q == CNT_W'(DATA_WIDTH-1)) begin
            cnt_d   = '0;
            state_d = RX_CRC;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RX_CRC: begin
          rx_crc_d = {rx_crc_q[CRC_WIDTH-2:0], dat_in};
          if (cnt_q == CNT_W'(CRC_WIDTH-1)) begin
            cnt_d   = '0;
            state_d = RX_END;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RX_END: begin
          data_read_d = shift_q;
          crc_error_d = (rx_crc_q != crc_q) || !dat_in;
          state_d     = RX_DONE;
        end
        ST_WAIT: if (!dat_in) state_d = ST_BITS;
        ST_BITS: begin
          crc_status_d = {crc_status_q[1:0], dat_in};
          if (cnt_q == CNT_W'(2)) begin
            cnt_d   = '0;
            state_d = ST_END;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_END: begin
          crc_error_d = (crc_status_q != 3'b010) || !dat_in;
          state_d     = ST_BUSY;
        end
        ST_BUSY: if (dat_in) state_d = ST_DONE;
        default: ;  // TX_DONE, RX_DONE, ST_DONE hold until the enable drops
      endcase
    end
  end

  always_ff @(posedge sd_clock) begin
    if (reset || reset_wrapper) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      crc_q        <= '0;
      rx_crc_q     <= '0;
      cnt_q        <= '0;
      crc_error_q  <= 1'b0;
      crc_status_q <= 3'b000;
      data_read_q  <= reset ? '0 : data_read_q;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      crc_q        <= crc_d;
      rx_crc_q     <= rx_crc_d;
      cnt_q        <= cnt_d;
      crc_error_q  <= crc_error_d;
      crc_status_q <= crc_status_d;
      data_read_q  <= data_read_d;
    end
  end

  always_comb begin
    dat_out = 1'b1;
    case (state_q)
      TX_START: dat_out = 1'b0;
      TX_DATA:  dat_out = shift_q[DATA_WIDTH-1];
      TX_CRC:   dat_out = crc_q[CRC_WIDTH-1];
      default:  ;
    endcase
  end

  assign transmission_complete = (state_q == TX_DONE);
  assign reception_complete    = (state_q == RX_DONE) || (state_q == ST_DONE);
  assign dataRead              = data_read_q;
  assign crc_error             = crc_error_q;
  assign crc_status            = crc_status_q;

endmodule

// File: tb/tb_dat_serial_wrapper.sv
// Bench for dat_serial_wrapper: directed frames with hand-computed CRCs; a negedge monitor
// compares transmitted frames and reception results against expected queues.
module tb_dat_serial_wrapper;

  logic        sd_clock = 1'b0;
  logic        reset, reset_wrapper, load_send;
  logic        enable_pts_wrapper, enable_stp_wrapper, waiting_response;
  logic [31:0] dataPARALLEL;
  logic        dat_in;
  logic        dat_out, transmission_complete, reception_complete;
  logic [31:0] dataRead;
  logic        crc_error;
  logic [2:0]  crc_status;

  int n_checks = 0;
  int n_errors = 0;

  // TX record: {start, data, crc, end}; RX record: {dataRead, crc_error, crc_status}
  logic [49:0] tx_exp_q[$];
  logic [35:0] rx_exp_q[$];
  logic [31:0] model_data;
  logic [2:0]  model_status;

  dat_serial_wrapper dut (
    .sd_clock              (sd_clock),
    .reset                 (reset),
    .reset_wrapper         (reset_wrapper),
    .load_send             (load_send),
    .enable_pts_wrapper    (enable_pts_wrapper),
    .enable_stp_wrapper    (enable_stp_wrapper),
    .waiting_response      (waiting_response),
    .dataPARALLEL          (dataPARALLEL),
    .dat_in                (dat_in),
    .dat_out               (dat_out),
    .transmission_complete (transmission_complete),
    .reception_complete    (reception_complete),
    .dataRead              (dataRead),
    .crc_error             (crc_error),
    .crc_status            (crc_status)
  );

  // ---------------- clock / reset ----------------
  always #5 sd_clock = ~sd_clock;

  task automatic tick();
    @(posedge sd_clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [49:0] win = '0;
  int          lat = 0;
  logic        tc_prev = 1'b0;
  logic        rc_prev = 1'b0;

  always @(negedge sd_clock) begin
    if (load_send && enable_pts_wrapper && !transmission_complete) lat = 0;
    else lat++;
    if (transmission_complete && !tc_prev) begin
      if (tx_exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL tx_unexpected: got completion with frame %0h, expected none", win);
      end else begin
        check("tx_frame", 64'(win), 64'(tx_exp_q.pop_front()));
        check("tx_latency", 64'(lat), 64'd51);
      end
    end
    if (reception_complete && !rc_prev) begin
      if (rx_exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rx_unexpected: got completion with dataRead %0h, expected none", dataRead);
      end else begin
        check("rx_result", 64'({dataRead, crc_error, crc_status}), 64'(rx_exp_q.pop_front()));
      end
    end
    win     = {win[48:0], dat_out};
    tc_prev = transmission_complete;
    rc_prev = reception_complete;
  end

  // ---------------- driver tasks ----------------
  task automatic send_tx(input logic [31:0] w, input logic [15:0] c, input bit reload);
    tx_exp_q.push_back({1'b0, w, c, 1'b1});
    enable_pts_wrapper = 1'b1;
    dataPARALLEL       = w;
    load_send          = 1'b1;
    tick();
    load_send = 1'b0;
    for (int i = 0; i < 60 && !transmission_complete; i++) tick();
    check("tx_complete_seen", 64'(transmission_complete), 64'd1);
    if (reload) begin
      dataPARALLEL = ~w;
      load_send    = 1'b1;
      tick();
      load_send = 1'b0;
    end
    tick();
    tick();
    check("tx_complete_held", 64'(transmission_complete), 64'd1);
    enable_pts_wrapper = 1'b0;
    tick();
    check("tx_complete_clear", 64'(transmission_complete), 64'd0);
    check("tx_idle_dat_out", 64'(dat_out), 64'd1);
  endtask

  task automatic rx_frame(input logic [31:0] w, input logic [15:0] c, input logic endb,
                          input logic exp_err);
    rx_exp_q.push_back({w, exp_err, model_status});
    model_data         = w;
    enable_stp_wrapper = 1'b1;
    waiting_response   = 1'b0;
    dat_in             = 1'b1;
    tick();
    tick();
    dat_in = 1'b0;
    tick();
    for (int i = 31; i >= 0; i--) begin dat_in = w[i]; tick(); end
    for (int i = 15; i >= 0; i--) begin dat_in = c[i]; tick(); end
    dat_in = endb;
    tick();
    dat_in = 1'b1;
    for (int i = 0; i < 5 && !reception_complete; i++) tick();
    check("rx_complete_seen", 64'(reception_complete), 64'd1);
    enable_stp_wrapper = 1'b0;
    tick();
    check("rx_complete_clear", 64'(reception_complete), 64'd0);
  endtask

  task automatic status_rx(input logic [2:0] token, input logic endb, input int busy,
                           input logic exp_err);
    rx_exp_q.push_back({model_data, exp_err, token});
    model_status       = token;
    enable_stp_wrapper = 1'b1;
    waiting_response   = 1'b1;
    dat_in             = 1'b1;
    tick();
    tick();
    dat_in = 1'b0;
    tick();
    for (int i = 2; i >= 0; i--) begin dat_in = token[i]; tick(); end
    dat_in = endb;
    tick();
    for (int i = 0; i < busy; i++) begin dat_in = 1'b0; tick(); end
    dat_in = 1'b1;
    check("st_busy_hold", 64'(reception_complete), 64'd0);
    tick();
    check("st_done_latency", 64'(reception_complete), 64'd1);
    enable_stp_wrapper = 1'b0;
    waiting_response   = 1'b0;
    tick();
    check("st_complete_clear", 64'(reception_complete), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset              = 1'b0;
    reset_wrapper      = 1'b0;
    load_send          = 1'b0;
    enable_pts_wrapper = 1'b0;
    enable_stp_wrapper = 1'b0;
    waiting_response   = 1'b0;
    dataPARALLEL       = '0;
    dat_in             = 1'b1;
    model_data         = '0;
    model_status       = '0;
    do_reset();

    check("rst_dat_out", 64'(dat_out), 64'd1);
    check("rst_tx_complete", 64'(transmission_complete), 64'd0);
    check("rst_rx_complete", 64'(reception_complete), 64'd0);
    check("rst_crc_error", 64'(crc_error), 64'd0);
    check("rst_crc_status", 64'(crc_status), 64'd0);
    check("rst_dataRead", 64'(dataRead), 64'd0);

    // Transmit: CRCs worked by hand for sparse words (linear, init 0)
    send_tx(32'h0000_0001, 16'h1021, 1'b0);
    send_tx(32'h0000_0003, 16'h3063, 1'b1);

    // Data receive: good, bad CRC, bad end bit, another good
    rx_frame(32'h0000_0001, 16'h1021, 1'b1, 1'b0);
    rx_frame(32'h0000_0001, 16'h1020, 1'b1, 1'b1);
    rx_frame(32'h0000_0001, 16'h1021, 1'b0, 1'b1);
    rx_frame(32'h0000_0100, 16'h3331, 1'b1, 1'b0);

    // Soft reset keeps the last received word
    reset_wrapper = 1'b1;
    tick();
    reset_wrapper = 1'b0;
    check("swrst_dataRead_kept", 64'(dataRead), 64'h100);
    check("swrst_crc_status", 64'(crc_status), 64'd0);
    model_status = 3'b000;

    // Status token + busy
    status_rx(3'b010, 1'b1, 5, 1'b0);
    status_rx(3'b101, 1'b1, 5, 1'b1);
    status_rx(3'b010, 1'b0, 0, 1'b1);

    // Abort a transmit at data bit 10, then send a clean frame straight away
    enable_pts_wrapper = 1'b1;
    dataPARALLEL       = 32'h0000_0000;
    load_send          = 1'b1;
    tick();
    load_send = 1'b0;
    repeat (11) tick();
    check("abort_pre_bit", 64'(dat_out), 64'd0);
    reset_wrapper = 1'b1;
    tick();
    reset_wrapper = 1'b0;
    check("abort_dat_out", 64'(dat_out), 64'd1);
    check("abort_no_complete", 64'(transmission_complete), 64'd0);
    send_tx(32'h0000_0101, 16'h2310, 1'b0);

    // Receive enable dropped mid-block: no completion, dataRead untouched
    enable_stp_wrapper = 1'b1;
    dat_in             = 1'b1;
    tick();
    tick();
    dat_in = 1'b0;
    tick();
    dat_in = 1'b1;
    repeat (5) tick();
    enable_stp_wrapper = 1'b0;
    tick();
    repeat (3) tick();
    check("rx_abort_no_complete", 64'(reception_complete), 64'd0);
    check("rx_abort_dataRead", 64'(dataRead), 64'(model_data));

    // Back-to-back write + status sequences, enables only
    send_tx(32'h0000_0002, 16'h2042, 1'b0);
    status_rx(3'b010, 1'b1, 2, 1'b0);
    send_tx(32'h0000_0001, 16'h1021, 1'b0);
    status_rx(3'b010, 1'b1, 0, 1'b0);

    repeat (5) tick();
    check("tx_queue_empty", 64'(tx_exp_q.size()), 64'd0);
    check("rx_queue_empty", 64'(rx_exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: got timeout, expected stimulus to finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
